// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection front end: default image geometry,
// line-window FSM encoding and the flattened window element index.
package edge_pkg;

  localparam int EDGE_PIXEL_DEPTH = 8;
  localparam int EDGE_COLUMNS     = 640;
  localparam int EDGE_FRAME_ROWS  = 480;
  localparam int EDGE_WINDOW      = 3;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } lwb_state_e;

  // Element (r,c) of a w x w window, r=0 oldest line, c=0 leftmost column.
  function automatic int win_idx(input int r, input int c, input int w);
    return r * w + c;
  endfunction

endpackage

// File: rtl/line_store_ram.sv
// Circular line memory: one slot per stored line, one write port and a
// registered read of the same column across every slot.
module line_store_ram
  import edge_pkg::*;
#(
  parameter int P_COLUMNS     = EDGE_COLUMNS,
  parameter int P_SLOTS       = EDGE_WINDOW - 1,
  parameter int P_PIXEL_DEPTH = EDGE_PIXEL_DEPTH
) (
  input  logic                               I_CLK,
  input  logic                               wr_en,
  input  logic [$clog2(P_SLOTS)-1:0]         wr_slot,
  input  logic [$clog2(P_COLUMNS)-1:0]       wr_col,
  input  logic [P_PIXEL_DEPTH-1:0]           wr_data,
  input  logic [$clog2(P_COLUMNS)-1:0]       rd_col,
  output logic [P_SLOTS*P_PIXEL_DEPTH-1:0]   rd_data_p1
);

  logic [P_PIXEL_DEPTH-1:0] mem [P_SLOTS][P_COLUMNS];

  // Read-during-write to the same location returns the previous contents.
  always_ff @(posedge I_CLK) begin
    if (wr_en) begin
      mem[wr_slot][wr_col] <= wr_data;
    end
    for (int s = 0; s < P_SLOTS; s++) begin
      rd_data_p1[s*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] <= mem[s][rd_col];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Raster-order pixel stream in, P_WINDOW x P_WINDOW neighbourhood out, one cycle latency.
// Optional LINE_WINDOW_COORD_EN adds registered window-centre coordinates.
module line_window_buffer
  import edge_pkg::*;
#(
  parameter int P_COLUMNS     = EDGE_COLUMNS,
  parameter int P_FRAME_ROWS  = EDGE_FRAME_ROWS,
  parameter int P_WINDOW      = EDGE_WINDOW,
  parameter int P_PIXEL_DEPTH = EDGE_PIXEL_DEPTH
) (
  input  logic                                        I_CLK,
  input  logic                                        I_RESET,
  input  logic                                        I_FRAME_START,
  input  logic [P_PIXEL_DEPTH-1:0]                    I_PIXEL,
  input  logic                                        I_VALID,
  output logic                                        O_READY,
  output logic [P_WINDOW*P_WINDOW*P_PIXEL_DEPTH-1:0]  O_WINDOW,
  output logic                                        O_VALID,
  input  logic                                        I_READY,
  output logic                                        O_LAST
`ifdef LINE_WINDOW_COORD_EN
  ,
  output logic [$clog2(P_FRAME_ROWS)-1:0]             O_CENTER_ROW,
  output logic [$clog2(P_COLUMNS)-1:0]                O_CENTER_COLUMN
`endif
);

  localparam int SLOTS = P_WINDOW - 1;
  localparam int COL_W = $clog2(P_COLUMNS);
  localparam int ROW_W = $clog2(P_FRAME_ROWS);
  localparam int PTR_W = $clog2(SLOTS);
  localparam int D     = P_PIXEL_DEPTH;
  localparam int WIN_W = P_WINDOW * P_WINDOW * D;
  localparam int HALF  = (P_WINDOW - 1) / 2;

  localparam logic [COL_W-1:0] COL_LAST       = COL_W'(P_COLUMNS - 1);
  localparam logic [COL_W-1:0] COL_FIRST_FULL = COL_W'(P_WINDOW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST       = ROW_W'(P_FRAME_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST_FULL = ROW_W'(P_WINDOW - 1);
  localparam logic [PTR_W-1:0] PTR_LAST       = PTR_W'(SLOTS - 1);

  lwb_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, rd_col;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PTR_W-1:0] wp_q, wp_d;
  logic             take, win_open;

  logic [SLOTS*D-1:0] line_p1;
  logic [D-1:0]       col_new [P_WINDOW];
  logic [WIN_W-1:0]   win_p1;
  logic               vld_p1, last_p1;

  assign O_READY  = !vld_p1 || I_READY;
  // A frame-start pulse wins over a coincident pixel, which is dropped.
  assign take     = I_VALID && O_READY && !I_FRAME_START;
  assign win_open = (state_q == S_STREAM) && (col_q >= COL_FIRST_FULL);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wp_d    = wp_q;
    if (I_FRAME_START) begin
      state_d = S_FILL;
      col_d   = '0;
      row_d   = '0;
      wp_d    = '0;
    end else if (take) begin
      if (state_q == S_FILL && row_q == ROW_FIRST_FULL) begin
        state_d = S_STREAM;
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          wp_d    = '0;
          state_d = S_FILL;
        end else begin
          row_d = row_q + 1'b1;
          wp_d  = (wp_q == PTR_LAST) ? '0 : wp_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      wp_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wp_q    <= wp_d;
    end
  end

  // Read one cycle ahead so the stored column is ready when the pixel arrives.
  assign rd_col = I_RESET ? '0 : col_d;

  line_store_ram #(
    .P_COLUMNS    (P_COLUMNS),
    .P_SLOTS      (SLOTS),
    .P_PIXEL_DEPTH(P_PIXEL_DEPTH)
  ) u_line_store (
    .I_CLK     (I_CLK),
    .wr_en     (take),
    .wr_slot   (wp_q),
    .wr_col    (col_q),
    .wr_data   (I_PIXEL),
    .rd_col    (rd_col),
    .rd_data_p1(line_p1)
  );

  // The slot at the write pointer holds the oldest line; later slots are newer.
  for (genvar r = 0; r < SLOTS; r++) begin : g_tap
    logic [PTR_W:0] slot_sum, slot;
    assign slot_sum   = {1'b0, wp_q} + (PTR_W+1)'(r);
    assign slot       = (slot_sum >= (PTR_W+1)'(SLOTS)) ? slot_sum - (PTR_W+1)'(SLOTS) : slot_sum;
    assign col_new[r] = line_p1[slot*D +: D];
  end
  assign col_new[P_WINDOW-1] = I_PIXEL;

  // ---- stage p1: window shift register and output qualifiers ----
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      win_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (take) begin
      for (int r = 0; r < P_WINDOW; r++) begin
        for (int c = 0; c < P_WINDOW - 1; c++) begin
          win_p1[win_idx(r, c, P_WINDOW)*D +: D] <= win_p1[win_idx(r, c + 1, P_WINDOW)*D +: D];
        end
        win_p1[win_idx(r, P_WINDOW - 1, P_WINDOW)*D +: D] <= col_new[r];
      end
      vld_p1  <= win_open;
      last_p1 <= win_open && (row_q == ROW_LAST) && (col_q == COL_LAST);
    end else if (O_READY) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign O_WINDOW = win_p1;
  assign O_VALID  = vld_p1;
  assign O_LAST   = last_p1;

`ifdef LINE_WINDOW_COORD_EN
  logic [ROW_W-1:0] crow_p1;
  logic [COL_W-1:0] ccol_p1;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      crow_p1 <= '0;
      ccol_p1 <= '0;
    end else if (take) begin
      crow_p1 <= row_q - ROW_W'(HALF);
      ccol_p1 <= col_q - COL_W'(HALF);
    end
  end

  assign O_CENTER_ROW    = crow_p1;
  assign O_CENTER_COLUMN = ccol_p1;
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: a frame-image reference model predicts
// every window; a separate monitor checks what the buffer presents.
module tb_line_window_buffer;

  localparam int P_COLUMNS     = 8;
  localparam int P_FRAME_ROWS  = 6;
  localparam int P_WINDOW      = 3;
  localparam int P_PIXEL_DEPTH = 8;
  localparam int WIN_W         = P_WINDOW * P_WINDOW * P_PIXEL_DEPTH;

  logic             I_CLK = 1'b0;
  logic             I_RESET = 1'b1;
  logic             I_FRAME_START = 1'b0;
  logic [7:0]       I_PIXEL = 8'h00;
  logic             I_VALID = 1'b0;
  logic             I_READY = 1'b1;
  logic             O_READY, O_VALID, O_LAST;
  logic [WIN_W-1:0] O_WINDOW;
`ifdef LINE_WINDOW_COORD_EN
  logic [2:0]       O_CENTER_ROW;
  logic [2:0]       O_CENTER_COLUMN;
`endif

  line_window_buffer #(
    .P_COLUMNS    (P_COLUMNS),
    .P_FRAME_ROWS (P_FRAME_ROWS),
    .P_WINDOW     (P_WINDOW),
    .P_PIXEL_DEPTH(P_PIXEL_DEPTH)
  ) dut (
    .I_CLK          (I_CLK),
    .I_RESET        (I_RESET),
    .I_FRAME_START  (I_FRAME_START),
    .I_PIXEL        (I_PIXEL),
    .I_VALID        (I_VALID),
    .O_READY        (O_READY),
    .O_WINDOW       (O_WINDOW),
    .O_VALID        (O_VALID),
    .I_READY        (I_READY),
    .O_LAST         (O_LAST)
`ifdef LINE_WINDOW_COORD_EN
    ,
    .O_CENTER_ROW   (O_CENTER_ROW),
    .O_CENTER_COLUMN(O_CENTER_COLUMN)
`endif
  );

  always #5 I_CLK = ~I_CLK;

  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [WIN_W-1:0] win;
    logic             last;
    int               crow;
    int               ccol;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] img [P_FRAME_ROWS][P_COLUMNS];
  int         m_row = 0, m_col = 0;
  int         n_vec = 0, n_err = 0, consumed = 0, last_cnt = 0;
  logic       acc;
  logic       held = 1'b0, rst_prev = 1'b0, held_last;
  logic [WIN_W-1:0] held_win;
  exp_t       mon_e;

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic pick_rdy(input int mode);
    return (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // Reference: remember the whole frame image, cut the window out of it.
  task automatic model_accept(input logic [7:0] p);
    exp_t e;
    img[m_row][m_col] = p;
    if (m_row >= P_WINDOW - 1 && m_col >= P_WINDOW - 1) begin
      e.cyc = cyc;
      e.win = '0;
      for (int r = 0; r < P_WINDOW; r++)
        for (int c = 0; c < P_WINDOW; c++)
          e.win[(r*P_WINDOW+c)*8 +: 8] = img[m_row-P_WINDOW+1+r][m_col-P_WINDOW+1+c];
      e.last = (m_row == P_FRAME_ROWS - 1) && (m_col == P_COLUMNS - 1);
      e.crow = m_row - (P_WINDOW - 1) / 2;
      e.ccol = m_col - (P_WINDOW - 1) / 2;
      exp_q.push_back(e);
    end
    if (m_col == P_COLUMNS - 1) begin
      m_col = 0;
      m_row = (m_row == P_FRAME_ROWS - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] p, input logic rdy, input logic fs,
                      input logic rst, output logic a);
    @(negedge I_CLK);
    I_VALID = v; I_PIXEL = p; I_READY = rdy; I_FRAME_START = fs; I_RESET = rst;
    #4;
    a = 1'b0;
    if (rst) begin
      m_row = 0; m_col = 0;
      exp_q.delete();
    end else if (fs) begin
      m_row = 0; m_col = 0;
    end else if (v && O_READY) begin
      model_accept(p);
      a = 1'b1;
    end
  endtask

  task automatic send_pixel(input int pixmode, input logic [7:0] base, input int rdy_mode, input int gaps);
    logic [7:0] p;
    logic       a;
    int         tries;
    if (gaps != 0) repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, pick_rdy(rdy_mode), 1'b0, 1'b0, a);
    p = (pixmode == 0) ? 8'(int'(base) + m_row * 16 + m_col) : 8'($urandom_range(0, 255));
    a = 1'b0;
    tries = 0;
    while (!a && tries < 200) begin
      step(1'b1, p, pick_rdy(rdy_mode), 1'b0, 1'b0, a);
      tries++;
    end
    if (!a) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted in 200 cycles", m_row, m_col);
    end
  endtask

  task automatic send_frame(input int pixmode, input logic [7:0] base, input int rdy_mode,
                            input int gaps, input int count, input int bp_directed);
    logic a;
    for (int i = 0; i < count; i++) begin
      if (bp_directed != 0 && m_row == 2 && m_col == 3) begin
        for (int k = 0; k < 5; k++) begin
          step(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, a);
          check("bp_o_ready", O_READY, 1'b0);
          check("bp_o_valid", O_VALID, 1'b1);
        end
      end
      send_pixel(pixmode, base, rdy_mode, gaps);
    end
  endtask

  task automatic drain(input int n);
    logic a;
    repeat (n) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, a);
  endtask

  // Monitor: checks each newly presented window against the queue head,
  // checks stability while stalled, pops on consumption.
  initial begin
    forever begin
      @(negedge I_CLK);
      #4;
      if (rst_prev) begin
        held = 1'b0;
      end else if (O_VALID === 1'b1) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_window: got %h, expected no window", O_WINDOW);
          end else begin
            mon_e = exp_q[0];
            check("latency_cycle", cyc, mon_e.cyc + 1);
            check("window", O_WINDOW, mon_e.win);
            check("last", O_LAST, mon_e.last);
`ifdef LINE_WINDOW_COORD_EN
            check("center_row", O_CENTER_ROW, 3'(mon_e.crow));
            check("center_column", O_CENTER_COLUMN, 3'(mon_e.ccol));
`endif
            if (O_LAST === 1'b1) last_cnt++;
          end
        end else begin
          check("hold_window", O_WINDOW, held_win);
          check("hold_last", O_LAST, held_last);
        end
        if (I_READY) begin
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            consumed++;
          end
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_win  = O_WINDOW;
          held_last = O_LAST;
        end
      end else if (held) begin
        n_vec++; n_err++;
        $display("FAIL dropped_window: O_VALID 0, required 1 while stalled");
        held = 1'b0;
      end
      rst_prev = I_RESET;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    check("reset_o_valid", O_VALID, 1'b0);
    check("reset_o_last", O_LAST, 1'b0);
    check("reset_o_window", O_WINDOW, '0);
    check("reset_o_ready", O_READY, 1'b1);

    // Pattern frame with a directed 5-cycle stall, then a back-to-back +0x80 frame.
    send_frame(0, 8'h00, 2, 0, 48, 1);
    send_frame(0, 8'h80, 0, 0, 48, 0);
    drain(6);
    check("windows_two_frames", consumed, 48);
    check("lasts_two_frames", last_cnt, 2);

    // Resync at (3,4), then a full random frame under random backpressure.
    send_frame(1, 8'h00, 1, 1, 28, 0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, acc);
    send_frame(1, 8'h00, 1, 1, 48, 0);
    drain(8);
    check("windows_after_resync", consumed, 80);
    check("lasts_after_resync", last_cnt, 3);

    // Reset mid-row while a window is stalled at the output.
    send_frame(1, 8'h00, 0, 0, 29, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    check("midreset_o_valid", O_VALID, 1'b0);
    check("midreset_o_last", O_LAST, 1'b0);
    check("midreset_o_window", O_WINDOW, '0);

    send_frame(1, 8'h00, 1, 1, 48, 0);
    send_frame(1, 8'h00, 1, 1, 48, 0);
    drain(10);
    check("windows_total", consumed, 136);
    check("lasts_total", last_cnt, 5);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
